// File: rtl/spike_rate_decoder.sv
// Purpose: counts spikes and the minimum inter-spike interval over programmable back-to-back windows.
// Latency: a window's result is at the FIFO head the cycle after its last RUN edge.
// Backpressure: a 2-entry FIFO absorbs results; a push into a full FIFO with no pop is lost and sets sticky dropped.

// Purpose: generic 2-entry FIFO with registered head; push into a full FIFO is accepted when a pop happens on the same edge.
// Latency: pushed data reaches pop_dat one cycle after the push edge when the FIFO was empty.
// Backpressure: pop_vld depends only on occupancy; drop_vld flags a push refused because the FIFO is full with no pop.
module fifo2 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat,
    output logic         drop_vld
);
    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic [1:0]   occ_q;
    logic         pop;

    assign pop_vld  = (occ_q != 2'd0);
    assign pop      = pop_vld && pop_rdy;
    assign pop_dat  = head_q;
    assign drop_vld = push_vld && (occ_q == 2'd2) && !pop;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            case ({push_vld, pop})
                2'b01: begin
                    head_q <= tail_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        head_q <= push_dat;
                        occ_q  <= 2'd1;
                    end else if (occ_q == 2'd1) begin
                        tail_q <= push_dat;
                        occ_q  <= 2'd2;
                    end
                end
                2'b11: begin
                    // Pop implies occupancy of at least one; occupancy is unchanged.
                    if (occ_q == 2'd1) begin
                        head_q <= push_dat;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= push_dat;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// Purpose: spike counter and minimum-ISI meter over programmable back-to-back windows of clock cycles.
// Latency: result visible on out_* one cycle after the window's last RUN edge.
// Backpressure: out_valid/out_ready drain a 2-entry FIFO; a result lost to a full FIFO sets sticky dropped.
module spike_rate_decoder #(
    parameter int WIN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIN_W-1:0] window_len,
    input  logic             spk,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic [CNT_W-1:0] out_min_isi,
    output logic             dropped
);
    typedef struct packed {
        logic [CNT_W-1:0] count;
        logic [CNT_W-1:0] min_isi;
    } result_t;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIN_W-1:0] win_len_q, win_len_d;
    logic [WIN_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] min_isi_q, min_isi_d;
    logic [CNT_W-1:0] since_q, since_d;
    logic             seen_q, seen_d;
    logic             dropped_q;

    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] isi;
    logic [CNT_W-1:0] min_upd;
    logic             win_last;
    logic             push_vld;
    result_t          push_dat;
    result_t          head_dat;
    logic             fifo_drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign cnt_inc  = spk ? sat_inc(cnt_q) : cnt_q;
    assign isi      = sat_inc(since_q);
    assign min_upd  = (spk && seen_q && (isi < min_isi_q)) ? isi : min_isi_q;
    assign win_last = (cyc_q == (win_len_q - WIN_W'(1)));
    assign push_dat = '{count: cnt_inc, min_isi: min_upd};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            win_len_q <= '0;
            cyc_q     <= '0;
            cnt_q     <= '0;
            min_isi_q <= '0;
            since_q   <= '0;
            seen_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_len_q <= win_len_d;
            cyc_q     <= cyc_d;
            cnt_q     <= cnt_d;
            min_isi_q <= min_isi_d;
            since_q   <= since_d;
            seen_q    <= seen_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        win_len_d = win_len_q;
        cyc_d     = cyc_q;
        cnt_d     = cnt_q;
        min_isi_d = min_isi_q;
        since_d   = since_q;
        seen_d    = seen_q;
        push_vld  = 1'b0;
        case (state_q)
            IDLE: begin
                // The spike on the starting edge is deliberately not counted.
                if (enable && (window_len != '0)) begin
                    state_d   = RUN;
                    win_len_d = window_len;
                    cyc_d     = '0;
                    cnt_d     = '0;
                    min_isi_d = '1;
                    since_d   = '0;
                    seen_d    = 1'b0;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (win_last) begin
                    // Close this window and open the next one on the same edge.
                    push_vld  = 1'b1;
                    win_len_d = window_len;
                    cyc_d     = '0;
                    cnt_d     = '0;
                    min_isi_d = '1;
                    since_d   = '0;
                    seen_d    = 1'b0;
                    if (window_len == '0) begin
                        state_d = IDLE;
                    end
                end else begin
                    cyc_d     = cyc_q + WIN_W'(1);
                    cnt_d     = cnt_inc;
                    min_isi_d = min_upd;
                    if (spk) begin
                        since_d = '0;
                        seen_d  = 1'b1;
                    end else if (seen_q) begin
                        since_d = isi;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    fifo2 #(.W($bits(result_t))) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_vld  (out_valid),
        .pop_rdy  (out_ready),
        .pop_dat  (head_dat),
        .drop_vld (fifo_drop)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dropped_q <= 1'b0;
        end else if (fifo_drop) begin
            dropped_q <= 1'b1;
        end
    end

    assign out_count   = head_dat.count;
    assign out_min_isi = head_dat.min_isi;
    assign dropped     = dropped_q;
endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder; expected window results are queued when
// the stimulus is driven and compared when the DUT hands them over.
module tb_spike_rate_decoder;
    logic       clk;
    logic       reset_n;
    logic       enable;
    logic [7:0] window_len;
    logic       spk;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_count;
    logic [7:0] out_min_isi;
    logic       dropped;

    int          checks;
    int          errors;
    logic [15:0] sb_q[$];
    logic        any_vld;

    spike_rate_decoder dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .window_len  (window_len),
        .spk         (spk),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_count   (out_count),
        .out_min_isi (out_min_isi),
        .dropped     (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // A pop happens on the coming edge when valid and ready are both high now.
    task automatic cycle();
        logic [15:0] exp;
        if (reset_n && out_valid && out_ready) begin
            checks++;
            assert (sb_q.size() > 0) else begin
                errors++;
                $error("FAIL sb_unexpected observed=0x%0h expected=no_result", {out_count, out_min_isi});
            end
            if (sb_q.size() > 0) begin
                exp = sb_q.pop_front();
                chk("sb_result", 32'({out_count, out_min_isi}), 32'(exp));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] len, input logic s);
        window_len = len;
        enable     = 1'b1;
        spk        = s;
        cycle();
    endtask

    task automatic stop();
        enable = 1'b0;
        spk    = 1'b0;
        cycle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        enable = 1'b0;
        window_len = 8'd0;
        spk = 1'b0;
        out_ready = 1'b0;

        // Reset and idle
        cycle();
        cycle();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_isi", 32'(out_min_isi), 32'd0);
        chk("rst_dropped", 32'(dropped), 32'd0);
        reset_n = 1'b1;
        any_vld = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (out_valid) any_vld = 1'b1;
        end
        chk("idle_valid", 32'(any_vld), 32'd0);

        // Basic window of 8, spikes at 1,4,5; start-edge spike ignored
        out_ready = 1'b1;
        start(8'd8, 1'b1);
        sb_q.push_back({8'd3, 8'd1});
        for (int i = 0; i < 8; i++) begin
            spk = (i == 1 || i == 4 || i == 5);
            cycle();
            if (i == 6) chk("w8_early_valid", 32'(out_valid), 32'd0);
        end
        chk("w8_valid", 32'(out_valid), 32'd1);
        chk("w8_count", 32'(out_count), 32'd3);
        chk("w8_isi", 32'(out_min_isi), 32'd1);
        sb_q.push_back({8'd2, 8'd7});
        for (int i = 0; i < 8; i++) begin
            spk = (i == 0 || i == 7);
            cycle();
        end
        chk("w8b_valid", 32'(out_valid), 32'd1);
        stop();

        // Single spike in a window of 10
        start(8'd10, 1'b0);
        sb_q.push_back({8'd1, 8'hFF});
        for (int i = 0; i < 10; i++) begin
            spk = (i == 3);
            cycle();
        end
        chk("w10_valid", 32'(out_valid), 32'd1);
        stop();

        // Window of 255 with spk held high
        start(8'd255, 1'b0);
        sb_q.push_back({8'hFF, 8'd1});
        for (int i = 0; i < 255; i++) begin
            spk = 1'b1;
            cycle();
        end
        spk = 1'b0;
        chk("w255_valid", 32'(out_valid), 32'd1);
        chk("w255_count", 32'(out_count), 32'hFF);
        stop();

        // Enable dropped mid-window, then a fresh window
        start(8'd8, 1'b0);
        for (int i = 0; i < 3; i++) begin
            spk = 1'b1;
            cycle();
        end
        spk = 1'b1;
        enable = 1'b0;
        cycle();
        chk("abort_valid", 32'(out_valid), 32'd0);
        start(8'd8, 1'b0);
        sb_q.push_back({8'd1, 8'hFF});
        for (int i = 0; i < 8; i++) begin
            spk = (i == 6);
            cycle();
        end
        chk("fresh_count", 32'(out_count), 32'd1);
        stop();

        // window_len goes to 0 mid-window: window completes, then IDLE
        start(8'd4, 1'b0);
        sb_q.push_back({8'd2, 8'd1});
        for (int i = 0; i < 4; i++) begin
            spk = (i >= 2);
            if (i == 1) window_len = 8'd0;
            cycle();
        end
        chk("len0_valid", 32'(out_valid), 32'd1);
        spk = 1'b0;
        repeat (6) cycle();
        chk("len0_idle_valid", 32'(out_valid), 32'd0);
        sb_q.push_back({8'd2, 8'd1});
        window_len = 8'd2;
        spk = 1'b1;
        repeat (3) cycle();
        chk("len2_valid", 32'(out_valid), 32'd1);
        stop();

        // L=1 with out_ready high: one result per cycle, nothing dropped
        start(8'd1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            spk = (i % 2 == 1);
            sb_q.push_back({8'(i % 2), 8'hFF});
            cycle();
        end
        stop();
        chk("l1_valid", 32'(out_valid), 32'd0);
        chk("l1_dropped", 32'(dropped), 32'd0);

        // Backpressure: four windows of 4 with out_ready low
        out_ready = 1'b0;
        start(8'd4, 1'b0);
        sb_q.push_back({8'd1, 8'hFF});
        sb_q.push_back({8'd2, 8'd1});
        for (int w = 0; w < 4; w++) begin
            for (int i = 0; i < 4; i++) begin
                spk = (w == 0) ? (i == 0) : (w == 1) ? (i < 2) : (w == 2);
                cycle();
            end
            if (w == 0) begin
                chk("bp_w1_valid", 32'(out_valid), 32'd1);
                chk("bp_w1_isi", 32'(out_min_isi), 32'hFF);
            end
            if (w == 1) begin
                chk("bp_head_stable", 32'(out_count), 32'd1);
                chk("bp_w2_dropped", 32'(dropped), 32'd0);
            end
            if (w == 2) chk("bp_w3_dropped", 32'(dropped), 32'd1);
        end
        chk("bp_w4_head", 32'({out_count, out_min_isi}), 32'h01FF);
        stop();
        out_ready = 1'b1;
        repeat (3) cycle();
        chk("bp_drained", 32'(out_valid), 32'd0);

        reset_n = 1'b0;
        out_ready = 1'b0;
        cycle();
        reset_n = 1'b1;
        chk("rst2_dropped", 32'(dropped), 32'd0);

        // Full FIFO with a pop coinciding with a window-end push
        start(8'd4, 1'b0);
        sb_q.push_back({8'd1, 8'hFF});
        sb_q.push_back({8'd2, 8'd1});
        sb_q.push_back({8'd2, 8'd2});
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 4; i++) begin
                spk = (w == 0) ? (i == 0) : (w == 1) ? (i < 2) : (i == 1 || i == 3);
                if (w == 2 && i == 3) out_ready = 1'b1;
                cycle();
                out_ready = 1'b0;
            end
        end
        chk("full_pop_dropped", 32'(dropped), 32'd0);
        chk("full_pop_head", 32'({out_count, out_min_isi}), 32'h0201);
        stop();
        out_ready = 1'b1;
        repeat (3) cycle();
        chk("full_pop_drained", 32'(out_valid), 32'd0);
        chk("full_pop_dropped_end", 32'(dropped), 32'd0);

        // Reset while a result is waiting
        out_ready = 1'b0;
        start(8'd2, 1'b0);
        repeat (2) cycle();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        reset_n = 1'b0;
        cycle();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_count", 32'(out_count), 32'd0);
        reset_n = 1'b1;
        enable = 1'b0;
        cycle();
        chk("post_rst_valid", 32'(out_valid), 32'd0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
